// File: rtl/router_arb_pkg.sv
// router_arb_pkg: shared mode constants, pointer width helper and lock FSM state type
package router_arb_pkg;

    localparam int ARB_MODE_STATIC = 0;
    localparam int ARB_MODE_RR     = 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Pointer width; a single requester still needs one bit to hold index 0
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_cell.sv
// rr_arbiter_cell: one arbiter with a descending wrap-around priority search from ptr; packet lock FSM under ROUTER_ARB_LOCK_EN
module rr_arbiter_cell
    import router_arb_pkg::*;
#(
    parameter int NUM_REQ  = 5,
    parameter int ARB_MODE = ARB_MODE_RR,
    parameter int IDX      = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
`ifdef ROUTER_ARB_LOCK_EN
    input  logic               lock,
`endif
    output logic [NUM_REQ-1:0] sel,
    output logic               gv
);

    localparam int              PW      = ptr_w(NUM_REQ);
    localparam logic [PW-1:0]   PTR_RST = PW'((IDX + NUM_REQ - 1) % NUM_REQ);
    localparam logic [PW-1:0]   PTR_MAX = PW'(NUM_REQ - 1);
    localparam bit              RR      = (ARB_MODE == ARB_MODE_RR);

    logic [PW-1:0]      ptr, ptr_nxt, g;
    logic [NUM_REQ-1:0] sel_rr;
    logic               found;
    int                 cand;

    // The winner moves to lowest priority: new pointer is one below it, wrapping
    function automatic logic [PW-1:0] dec(input logic [PW-1:0] x);
        return (x == '0) ? PTR_MAX : x - 1'b1;
    endfunction

    // Priority search: ptr, ptr-1, ..., 0, NUM_REQ-1, ..., ptr+1; first set request wins
    always_comb begin
        sel_rr = '0;
        g      = '0;
        found  = 1'b0;
        cand   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr) + NUM_REQ - k) % NUM_REQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                sel_rr[cand] = 1'b1;
                g           = PW'(cand);
            end
        end
    end

`ifdef ROUTER_ARB_LOCK_EN
    arb_state_t         state, state_nxt;
    logic [PW-1:0]      owner, owner_nxt;
    logic [NUM_REQ-1:0] owner_oh;

    assign owner_oh = NUM_REQ'(1) << owner;
    assign sel      = (state == LOCKED) ? (owner_oh & req) : sel_rr;
    assign gv       = |sel;

    // Lock FSM: a locked grant holds ownership and defers the pointer update until release
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        if (state == IDLE) begin
            if (en && gv && lock) begin
                state_nxt = LOCKED;
                owner_nxt = g;
            end else if (en && gv && RR) begin
                ptr_nxt = dec(g);
            end
        end else if (en && !lock) begin
            state_nxt = IDLE;
            ptr_nxt   = RR ? dec(owner) : ptr;
        end
    end

    // Lock state and owner registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end
`else
    assign sel = sel_rr;
    assign gv  = |sel;

    // Round-robin advance on a consumed grant; static mode keeps the reset pointer
    always_comb begin
        ptr_nxt = ptr;
        if (en && gv && RR)
            ptr_nxt = dec(g);
    end
`endif

    // Priority pointer register
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= PTR_RST;
        else
            ptr <= ptr_nxt;
    end

endmodule

// File: rtl/router_input_arbiter_rr.sv
// router_input_arbiter_rr: bank of NUM_ARBS independent input arbiters; optional packet lock via ROUTER_ARB_LOCK_EN
module router_input_arbiter_rr
    import router_arb_pkg::*;
#(
    parameter int NUM_ARBS = 5,
    parameter int NUM_REQ  = 5,
    parameter int ARB_MODE = ARB_MODE_RR
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_ARBS*NUM_REQ-1:0] select_requests,
    output logic [NUM_ARBS*NUM_REQ-1:0] select,
    output logic [NUM_ARBS-1:0]         grant_valid,
`ifdef ROUTER_ARB_LOCK_EN
    input  logic [NUM_ARBS-1:0]         lock,
`endif
    input  logic [NUM_ARBS-1:0]         EN_next
);

    for (genvar i = 0; i < NUM_ARBS; i++) begin : g_arb
        rr_arbiter_cell #(
            .NUM_REQ  (NUM_REQ),
            .ARB_MODE (ARB_MODE),
            .IDX      (i)
        ) u_cell (
            .clk  (CLK),
            .rst  (RST),
            .req  (select_requests[i*NUM_REQ +: NUM_REQ]),
            .en   (EN_next[i]),
`ifdef ROUTER_ARB_LOCK_EN
            .lock (lock[i]),
`endif
            .sel  (select[i*NUM_REQ +: NUM_REQ]),
            .gv   (grant_valid[i])
        );
    end

endmodule

// File: tb/tb_router_input_arbiter_rr.sv
// tb_router_input_arbiter_rr: directed checks of a round-robin and a static instance
module tb_router_input_arbiter_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic [24:0] req_rr, req_st, sel_rr, sel_st;
    logic [4:0]  gv_rr, gv_st, en_rr, en_st;
`ifdef ROUTER_ARB_LOCK_EN
    logic [4:0]  lk_rr, lk_st;
`endif
    int n_chk = 0;
    int n_pass = 0;

    router_input_arbiter_rr #(.NUM_ARBS(5), .NUM_REQ(5), .ARB_MODE(1)) dut_rr (
        .CLK(clk), .RST(rst), .select_requests(req_rr), .select(sel_rr),
        .grant_valid(gv_rr),
`ifdef ROUTER_ARB_LOCK_EN
        .lock(lk_rr),
`endif
        .EN_next(en_rr)
    );

    router_input_arbiter_rr #(.NUM_ARBS(5), .NUM_REQ(5), .ARB_MODE(0)) dut_st (
        .CLK(clk), .RST(rst), .select_requests(req_st), .select(sel_st),
        .grant_valid(gv_st),
`ifdef ROUTER_ARB_LOCK_EN
        .lock(lk_st),
`endif
        .EN_next(en_st)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, got[4:0], exp[4:0]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] sl(input logic [24:0] v, input int i);
        return v[i*5 +: 5];
    endfunction

    logic [4:0] exp_a0 [6] = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b10000};
    logic [4:0] exp_b0 [3] = '{5'b10000, 5'b01000, 5'b00100};
    logic [4:0] exp_b1 [3] = '{5'b00001, 5'b10000, 5'b00010};

    initial begin
        rst = 1'b1; req_rr = '0; req_st = '0; en_rr = '0; en_st = '0;
`ifdef ROUTER_ARB_LOCK_EN
        lk_rr = '0; lk_st = '0;
`endif
        tick(); tick();
        chk("rst_zero_sel", {7'd0, sel_rr}, 32'd0);
        chk("rst_zero_gv", {27'd0, gv_rr}, 32'd0);
        rst = 1'b0;
        tick();
        // Reset pointers: arb0..4 -> 4,0,1,2,3
        req_rr = {5'b11111, 5'b11111, 5'b11111, 5'b10011, 5'b11111};
        #1;
        chk("t1_arb0", sl(sel_rr, 0), 5'b10000);
        chk("t1_arb1", sl(sel_rr, 1), 5'b00001);
        chk("t1_arb2", sl(sel_rr, 2), 5'b00010);
        chk("t1_arb3", sl(sel_rr, 3), 5'b00100);
        chk("t1_arb4", sl(sel_rr, 4), 5'b01000);
        chk("t1_gv", {27'd0, gv_rr}, 32'h1f);
        // Round-robin rotation on arbiter 0
        en_rr = 5'b00001;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t2_rot%0d", k), sl(sel_rr, 0), exp_a0[k]);
            if (k < 5) tick();
        end
        chk("t2_arb1_idle", sl(sel_rr, 1), 5'b00001);
        // Simultaneous independent updates on arbiters 0 and 1
        en_rr = 5'b00011;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("sim_a0_%0d", k), sl(sel_rr, 0), exp_b0[k]);
            chk($sformatf("sim_a1_%0d", k), sl(sel_rr, 1), exp_b1[k]);
            tick();
        end
        chk("sim_a0_end", sl(sel_rr, 0), 5'b00010);
        en_rr = '0;
        // Empty requests with EN_next on arbiter 3 leave its pointer alone
        req_rr[15 +: 5] = 5'b00000;
        en_rr = 5'b01000;
        #1;
        chk("t4_sel0", sl(sel_rr, 3), 5'b00000);
        chk("t4_gv0", {31'd0, gv_rr[3]}, 32'd0);
        tick(); tick();
        en_rr = '0;
        req_rr[15 +: 5] = 5'b11111;
        #1;
        chk("t4_ptr_kept", sl(sel_rr, 3), 5'b00100);
        // Reset overrides EN_next mid-operation
        req_rr = '1;
        en_rr = '1;
        rst = 1'b1;
        tick();
        #1;
        chk("t5_in_rst", sl(sel_rr, 0), 5'b10000);
        rst = 1'b0;
        en_rr = '0;
        tick();
        chk("t5_after_a0", sl(sel_rr, 0), 5'b10000);
        chk("t5_after_a1", sl(sel_rr, 1), 5'b00001);
        // Static mode: arbiter 2 pointer frozen at 1
        req_st[10 +: 5] = 5'b11111;
        en_st = 5'b00100;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("t3_static%0d", k), sl(sel_st, 2), 5'b00010);
            tick();
        end
        req_st[10 +: 5] = 5'b11100;
        #1;
        chk("t3_static_wrap", sl(sel_st, 2), 5'b10000);
        tick();
        chk("t3_static_hold", sl(sel_st, 2), 5'b10000);
        chk("t3_static_a0", sl(sel_st, 0), 5'b00000);
        en_st = '0;
`ifdef ROUTER_ARB_LOCK_EN
        // Packet lock on arbiter 0 (rr instance pointer is at reset value 4)
        req_rr[0 +: 5] = 5'b11111;
        en_rr = 5'b00001;
        lk_rr = 5'b00001;
        #1;
        chk("t6_grant", sl(sel_rr, 0), 5'b10000);
        tick();
        en_rr = '0;
        req_rr[0 +: 5] = 5'b01111;
        #1;
        chk("t6_masked", sl(sel_rr, 0), 5'b00000);
        chk("t6_masked_gv", {31'd0, gv_rr[0]}, 32'd0);
        req_rr[0 +: 5] = 5'b11111;
        #1;
        chk("t6_owner", sl(sel_rr, 0), 5'b10000);
        en_rr = 5'b00001;
        lk_rr = '0;
        tick();
        en_rr = '0;
        #1;
        chk("t6_release", sl(sel_rr, 0), 5'b01000);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
